// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one W-bit ALU among NREQ requesters with round-robin grants
// and a single registered result stage that can be stalled by the consumer.
module alu_rr_sched #(
  parameter int W    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_z,
  output logic [4:0]        rsp_flags,
  output logic              rsp_err
);
  logic [IDW-1:0] ptr, gid;
  logic           acc, carry, ovf, err;
  logic [2:0]     op;
  logic [W-1:0]   x, y, z;
  logic [W:0]     sum, dif;

  // Scan downward so the requester closest after ptr is the last match and wins.
  function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    pick = p;
    for (int k = NREQ; k >= 1; k--)
      if (v[(int'(p) + k) % NREQ]) pick = IDW'((int'(p) + k) % NREQ);
  endfunction

  assign gid       = pick(req_valid, ptr);
  assign acc       = rst_n & en & (|req_valid) & (~rsp_valid | rsp_ready);
  assign req_ready = acc ? ({{(NREQ-1){1'b0}}, 1'b1} << gid) : '0;
  assign op        = req_op[3*gid +: 3];
  assign x         = req_a[W*gid +: W];
  assign y         = req_b[W*gid +: W];
  assign sum       = {1'b0, x} + {1'b0, y};
  assign dif       = {1'b0, x} - {1'b0, y};

  always_comb begin
    z     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      3'b000: begin
        z     = sum[W-1:0];
        carry = sum[W];
        ovf   = (x[W-1] == y[W-1]) & (z[W-1] != x[W-1]);
      end
      3'b001: begin
        z     = dif[W-1:0];
        carry = dif[W];
        ovf   = (x[W-1] != y[W-1]) & (z[W-1] != x[W-1]);
      end
      3'b010:  z = x & y;
      3'b011:  z = x | y;
      3'b100:  z = x ^ y;
      3'b101:  z = ~x;
      3'b110:  z = x;
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr       <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else if (acc) begin
      ptr       <= gid;
      rsp_valid <= 1'b1;
      rsp_id    <= gid;
      rsp_z     <= z;
      rsp_flags <= {z[W-1], ~|z, carry, ~^z, ovf};
      rsp_err   <= err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
endmodule
